// File: rtl/hilo_unit.sv
// Execute-stage HI/LO unit. It holds the architectural HI and LO registers.
// MTHI, MTLO, MULT and MULTU complete in a single cycle. DIV and DIVU use an
// iterative radix-2 restoring divider that stalls the front of the pipeline
// while it runs.
module hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  input  logic [2:0]       hilo_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             stall
);

  typedef enum logic [2:0] {
    OP_MTHI  = 3'b000,
    OP_MTLO  = 3'b001,
    OP_MULT  = 3'b010,
    OP_MULTU = 3'b011,
    OP_DIV   = 3'b100,
    OP_DIVU  = 3'b101
  } hilo_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] divisor, rem, quo;
  logic [CNT_W-1:0] cnt;
  logic             q_neg, r_neg;

  // An operation is taken only from IDLE, and only when it is not being
  // flushed.
  logic accept, is_div, div_signed, div_start, last_step;
  assign accept     = (state == IDLE) && op_valid && !flush;
  assign is_div     = (hilo_op == OP_DIV) || (hilo_op == OP_DIVU);
  assign div_signed = (hilo_op == OP_DIV);
  assign div_start  = accept && is_div && (b != '0);
  assign last_step  = (cnt == CNT_W'(WIDTH - 1));

  // One multiplier serves both MULT and MULTU. The operands are widened to
  // WIDTH+1 bits, using sign extension for MULT and zero extension for MULTU.
  // The product is then formed on fully extended vectors, so its low 2*WIDTH
  // bits are exact in both cases.
  logic [WIDTH:0]     mul_a, mul_b;
  logic [2*WIDTH+1:0] prod;
  assign mul_a = {(hilo_op == OP_MULT) && a[WIDTH-1], a};
  assign mul_b = {(hilo_op == OP_MULT) && b[WIDTH-1], b};
  assign prod  = {{(WIDTH+1){mul_a[WIDTH]}}, mul_a} * {{(WIDTH+1){mul_b[WIDTH]}}, mul_b};

  // A signed divide runs on magnitudes. The signs are reapplied in FIX.
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = (div_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (div_signed && b[WIDTH-1]) ? -b : b;

  // Restoring step: shift the quotient MSB into the remainder, then
  // trial-subtract the divisor. Bit WIDTH of the result is the borrow.
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_shift;
  assign rem_shift = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign trial     = {rem, quo[WIDTH-1]} - {1'b0, divisor};

  // State register.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the values from before the edge regardless of block order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: flush returns the divider to IDLE from any state.
  always_comb begin
    // NOTE: the default assignment first means no path leaves state_nxt
    // unassigned, so no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (div_start) state_nxt = RUN;
      RUN:     if (flush) state_nxt = IDLE;
               else if (last_step) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: stall during the accept cycle and all WIDTH RUN cycles.
  always_comb begin
    stall = div_start || (state == RUN);
  end

  // Datapath: HI/LO writes, divider setup, iteration, and sign fix-up.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi      <= '0;
      lo      <= '0;
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            case (hilo_op)
              OP_MTHI:  hi <= a;
              OP_MTLO:  lo <= a;
              OP_MULT,
              OP_MULTU: {hi, lo} <= prod[2*WIDTH-1:0];
              OP_DIV,
              OP_DIVU: begin
                if (b != '0) begin
                  divisor <= b_mag;
                  quo     <= a_mag;
                  rem     <= '0;
                  cnt     <= '0;
                  q_neg   <= div_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_neg   <= div_signed && a[WIDTH-1];
                end
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_shift;
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          if (!flush) begin
            lo <= q_neg ? -quo : quo;
            hi <= r_neg ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_o = hi;
  assign lo_o = lo;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit. A reference model computes the expected
// HI/LO pair when each operation is driven and pushes it to a queue. The pair
// is popped and compared once the DUT result is visible.
module tb_hilo_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn;
  logic         op_valid;
  logic [2:0]   hilo_op;
  logic [W-1:0] a, b;
  logic         flush;
  logic [W-1:0] hi_o, lo_o;
  logic         stall;

  hilo_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .op_valid (op_valid),
    .hilo_op  (hilo_op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_hi, m_lo;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: update m_hi/m_lo as the architecture requires.
  task automatic model(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [63:0] p;
    longint      q, r;
    case (op)
      3'b000: m_hi = av;
      3'b001: m_lo = av;
      3'b010: begin
        p = 64'(longint'($signed(av)) * longint'($signed(bv)));
        {m_hi, m_lo} = p;
      end
      3'b011: begin
        p = {32'b0, av} * {32'b0, bv};
        {m_hi, m_lo} = p;
      end
      3'b100: if (bv != 0) begin
        q = longint'($signed(av)) / longint'($signed(bv));
        r = longint'($signed(av)) % longint'($signed(bv));
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      3'b101: if (bv != 0) begin
        m_lo = av / bv;
        m_hi = av % bv;
      end
      default: ;
    endcase
  endtask

  // Drive one operation for a single cycle. st returns stall as seen in the
  // drive cycle.
  task automatic issue(input string tag, input logic [2:0] op, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic fl, output logic st);
    exp_t e;
    @(negedge clk);
    op_valid = 1'b1; hilo_op = op; a = av; b = bv; flush = fl;
    #1 st = stall;
    if (!fl) model(op, av, bv);
    e.tag = tag; e.hi = m_hi; e.lo = m_lo;
    sb.push_back(e);
    @(posedge clk);
    #1 op_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic compare_next();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_hi"}, hi_o, e.hi);
      check({e.tag, "_lo"}, lo_o, e.lo);
    end
  endtask

  task automatic single(input string tag, input logic [2:0] op, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic fl);
    logic st;
    issue(tag, op, av, bv, fl, st);
    check({tag, "_stall"}, 32'(st), 32'd0);
    compare_next();
  endtask

  // A divide with nonzero divisor. Count the stall cycles, then compare the
  // result on the cycle after FIX.
  task automatic run_div(input string tag, input logic [2:0] op, input logic [W-1:0] av,
                         input logic [W-1:0] bv);
    logic st;
    int   n;
    issue(tag, op, av, bv, 1'b0, st);
    check({tag, "_stall_accept"}, 32'(st), 32'd1);
    n = 1;
    while (stall === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check({tag, "_stall_cycles"}, 32'(n), 32'(W + 1));
    @(posedge clk); #1;
    compare_next();
  endtask

  initial begin
    logic st;
    int   hi_cnt;
    resetn = 1'b0; op_valid = 1'b0; hilo_op = '0; a = '0; b = '0; flush = 1'b0;
    m_hi = '0; m_lo = '0;
    #12;
    check("reset_hi", hi_o, 32'd0);
    check("reset_lo", lo_o, 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    @(negedge clk) resetn = 1'b1;

    single("mthi", 3'b000, 32'h1234_5678, 32'h0, 1'b0);
    single("mtlo", 3'b001, 32'h9ABC_DEF0, 32'h0, 1'b0);
    single("mthi_flushed", 3'b000, 32'hDEAD_BEEF, 32'h0, 1'b1);
    single("noop_code", 3'b111, 32'h1111_1111, 32'h2222_2222, 1'b0);
    single("mult_neg", 3'b010, 32'hFFFF_FFFE, 32'd3, 1'b0);
    single("multu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    single("mult_mixed", 3'b010, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);

    run_div("divu_100_7", 3'b101, 32'd100, 32'd7);
    run_div("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2);
    run_div("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("div_7_m2", 3'b100, 32'd7, 32'hFFFF_FFFE);
    run_div("divu_big", 3'b101, 32'hFFFF_FFFF, 32'h0001_0000);

    // Divide by zero leaves the preset HI/LO intact and never stalls.
    single("preset_hi", 3'b000, 32'd5, 32'd0, 1'b0);
    single("preset_lo", 3'b001, 32'd6, 32'd0, 1'b0);
    single("div_by_zero", 3'b100, 32'd77, 32'd0, 1'b0);
    hi_cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (stall === 1'b1) hi_cnt++;
    end
    check("div0_no_stall", 32'(hi_cnt), 32'd0);

    // Flush in the middle of a divide: no write, and stall drops afterwards.
    issue("div_flushed", 3'b100, 32'd100, 32'd7, 1'b0, st);
    void'(sb.pop_back());
    m_hi = 32'd5; m_lo = 32'd6;
    check("flush_stall_accept", 32'(st), 32'd1);
    repeat (10) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    #1 check("flush_cycle_stall", 32'(stall), 32'd1);
    @(posedge clk); #1 flush = 1'b0;
    check("after_flush_stall", 32'(stall), 32'd0);
    repeat (W + 2) @(posedge clk);
    #1;
    check("after_flush_hi", hi_o, m_hi);
    check("after_flush_lo", lo_o, m_lo);
    single("mult_3_4", 3'b010, 32'd3, 32'd4, 1'b0);

    // Asynchronous reset in the middle of a divide.
    issue("divu_reset", 3'b101, 32'd1000, 32'd3, 1'b0, st);
    void'(sb.pop_back());
    repeat (5) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("midreset_hi", hi_o, 32'd0);
    check("midreset_lo", lo_o, 32'd0);
    check("midreset_stall", 32'(stall), 32'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk) resetn = 1'b1;
    single("mtlo_after_reset", 3'b001, 32'h0000_0055, 32'h0, 1'b0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog: a hang still ends with a report.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Execute-stage HI/LO block, directly downstream of the main and ALU decoders; it consumes the hilowrite path and the mult/div/move operation select.
- Holds the architectural HI and LO registers and performs MTHI, MTLO, MULT and MULTU in one cycle.
- Performs DIV and DIVU with an iterative radix-2 restoring divider, raising stall while the divide runs.
- Outputs feed the hilotoreg mux for MFHI and MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- op_valid  input  1  a HI/LO operation is present in EX this cycle.
- hilo_op  input  3  operation select: 000 MTHI, 001 MTLO, 010 MULT, 011 MULTU, 100 DIV, 101 DIVU; other codes are no-ops.
- a  input  WIDTH  rs operand.
- b  input  WIDTH  rt operand.
- flush  input  1  pipeline flush (exception or redirect).
- hi_o  output  WIDTH  HI register.
- lo_o  output  WIDTH  LO register.
- stall  output  1  holds EX and all earlier stages.

Behaviour:
- Reset (resetn low, asynchronous): hi_o = 0, lo_o = 0, state = IDLE, counter = 0, stall = 0. Reset asserted mid-divide aborts the divide; no partial result is written.
- hi_o and lo_o are registered. A write is visible on the cycle after its edge. There is no internal bypass.
- States: IDLE, RUN, FIX.
- IDLE, accepting only when op_valid=1 and flush=0:
  - MTHI: hi <= a. MTLO: lo <= a. No stall.
  - MULT: {hi,lo} <= signed a*b, full 64 bits. MULTU: same, unsigned. No stall. Latency 1 edge.
  - DIV/DIVU with b != 0:
    - latch |a| and |b| (DIV) or raw a and b (DIVU);
    - latch quotient sign = a[31]^b[31] and remainder sign = a[31] (both forced 0 for DIVU);
    - clear remainder and counter; go to RUN.
    - stall = 1 combinationally in this cycle.
  - DIV/DIVU with b == 0: HI and LO unchanged, no stall, stay in IDLE.
  - flush=1 in IDLE suppresses any write.
- RUN:
  - stall = 1.
  - Each cycle performs one restoring step: shift {rem, quo} left by 1, trial-subtract the divisor, keep the result if non-negative and set quotient bit 1.
  - Counter increments once per step. After the step with counter = WIDTH-1, go to FIX.
  - Exactly WIDTH RUN cycles.
- FIX:
  - stall = 0.
  - Negate the quotient if its sign flag is set and the remainder if its sign flag is set (two's complement, WIDTH-bit truncation).
  - Write lo <= quotient and hi <= remainder at the edge; return to IDLE.
  - The dividing instruction leaves EX on this same edge, so op_valid is not re-sampled for it.
- Divide timing: stall is high for WIDTH+1 cycles (accept cycle plus WIDTH RUN cycles). Result is visible in hi_o/lo_o WIDTH+2 cycles after the accept cycle.
- Overflow case: 0x80000000 / 0xFFFFFFFF (signed) gives lo = 0x80000000, hi = 0 via truncation; no trap.
- flush in RUN or FIX: return to IDLE at the next edge with HI/LO unchanged. stall is low from the following cycle. flush has priority over the FIX write.
- op_valid while in RUN is ignored (the pipeline is stalled).
- The unsigned multiply and trial subtractor operate on WIDTH+1 bits internally.

Test Plan:
- Reset, then MTHI a=0x12345678 followed by MTLO a=0x9ABCDEF0 → hi_o=0x12345678 and lo_o=0x9ABCDEF0, one cycle after each edge; stall never asserted.
- MULT a=0xFFFFFFFE (-2), b=3 → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA. MULTU a=b=0xFFFFFFFF → hi_o=0xFFFFFFFE, lo_o=0x00000001.
- DIVU a=100, b=7 → stall high for exactly 33 cycles, then lo_o=14, hi_o=2. DIV a=0xFFFFFFF9 (-7), b=2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → lo_o=0x80000000, hi_o=0. DIV with b=0 and preset HI/LO=5/6 → HI/LO remain 5/6, stall never high.
- DIV a=100, b=7 with flush pulsed at RUN cycle 10 → stall low from the cycle after the flush, HI/LO unchanged, and a following MULT 3*4 gives lo_o=12.
- DIV in progress with resetn pulled low mid-cycle, asynchronously → hi_o=lo_o=0 and stall=0 immediately; after release, IDLE accepts a new MTLO.
